// File: rtl/sigmoid_scheduler.sv
// sigmoid_scheduler: round-robin sharing of one fixed-latency sigmoid pipeline
// among NUM_REQ requesters, with tagged issue and a credit-protected response FIFO.
module sigmoid_scheduler #(
  parameter int NUM_REQ     = 4,
  parameter int DATA_W      = 16,
  parameter int SIG_LATENCY = 5,
  parameter int FIFO_DEPTH  = 4
) (
  input  logic                       clock,
  input  logic                       reset,
  input  logic [NUM_REQ-1:0]         req_valid,
  input  logic [NUM_REQ*DATA_W-1:0]  req_data,
  output logic [NUM_REQ-1:0]         req_ready,
  output logic [DATA_W-1:0]          sig_in_data,
  input  logic [DATA_W-1:0]          sig_out_data,
  output logic                       resp_valid,
  output logic [$clog2(NUM_REQ)-1:0] resp_id,
  output logic [DATA_W-1:0]          resp_data,
  input  logic                       resp_ready,
  output logic                       busy
);
  localparam int IW = $clog2(NUM_REQ);
  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = AW + 1;

  logic [IW-1:0]                 r_rr_ptr;
  logic [IW-1:0]                 w_gid;
  logic [IW-1:0]                 w_idx;
  logic                          w_found;
  logic                          w_issue;
  logic                          w_push;
  logic                          w_pop;
  logic [CW-1:0]                 r_inflight;
  logic [CW-1:0]                 r_count;
  logic [AW-1:0]                 r_wr;
  logic [AW-1:0]                 r_rd;
  logic [SIG_LATENCY:0]          r_tag_v;
  logic [(SIG_LATENCY+1)*IW-1:0] r_tag_id;
  logic [IW+DATA_W-1:0]          r_mem [FIFO_DEPTH];
  logic [DATA_W-1:0]             r_sig_in;

  always_comb begin
    w_found = 1'b0;
    w_gid   = '0;
    w_idx   = '0;
    for (int k = 0; k < NUM_REQ; k++) begin
      w_idx = IW'((int'(r_rr_ptr) + k) % NUM_REQ);
      if (!w_found && req_valid[w_idx]) begin
        w_found = 1'b1;
        w_gid   = w_idx;
      end
    end
  end

  // A slot is reserved for every operand in flight, so a retiring result never finds the FIFO full
  assign w_issue     = w_found && (({1'b0, r_count} + {1'b0, r_inflight}) < (CW+1)'(FIFO_DEPTH));
  assign req_ready   = w_issue ? (NUM_REQ'(1) << w_gid) : '0;
  assign w_push      = r_tag_v[SIG_LATENCY];
  assign resp_valid  = r_count != '0;
  assign w_pop       = resp_valid && resp_ready;
  assign {resp_id, resp_data} = resp_valid ? r_mem[r_rd] : '0;
  assign busy        = (r_inflight != '0) || resp_valid;
  assign sig_in_data = r_sig_in;

  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      r_rr_ptr   <= '0;
      r_sig_in   <= '0;
      r_tag_v    <= '0;
      r_tag_id   <= '0;
      r_inflight <= '0;
      r_count    <= '0;
      r_wr       <= '0;
      r_rd       <= '0;
    end else begin
      if (w_issue) r_rr_ptr <= (w_gid == IW'(NUM_REQ-1)) ? '0 : w_gid + 1'b1;
      r_sig_in   <= w_issue ? req_data[w_gid*DATA_W +: DATA_W] : '0;
      r_tag_v    <= {r_tag_v[SIG_LATENCY-1:0], w_issue};
      r_tag_id   <= {r_tag_id[SIG_LATENCY*IW-1:0], w_gid};
      r_inflight <= r_inflight + CW'(w_issue) - CW'(w_push);
      r_count    <= r_count + CW'(w_push) - CW'(w_pop);
      if (w_push) r_wr <= r_wr + 1'b1;
      if (w_pop) r_rd <= r_rd + 1'b1;
    end
  end

  always_ff @(posedge clock) begin
    if (w_push) r_mem[r_wr] <= {r_tag_id[SIG_LATENCY*IW +: IW], sig_out_data};
  end
endmodule
